dcache_direct: RTL
==================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the processor memory port (mem_addr/rd_req/wr_req/busy/ack) and the delayed memory model.
- The processor talks to it with the same request/busy/ack handshake it uses towards memory, so it drops in without processor changes.
- Hits complete in 1 cycle. Misses and all writes are forwarded to memory.

Parameters:
- NUM_LINES, 16, number of one-word lines; power of two, >= 2.
- IDX_BITS, $clog2(NUM_LINES), index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  32  byte address; bits [1:0] ignored (word access only)
- cpu_rd_req  in  1  read request pulse
- cpu_wr_req  in  1  write request pulse
- cpu_wr_data  in  32  write data
- cpu_rd_data  out  32  read data; valid in the cpu_ack cycle
- cpu_busy  out  1  request in flight; new requests ignored while high
- cpu_ack  out  1  1-cycle completion pulse
- mem_addr  out  32  address to memory
- mem_rd_req  out  1  memory read pulse
- mem_wr_req  out  1  memory write pulse
- mem_wr_data  out  32  memory write data
- mem_rd_data  in  32  memory read data; valid with mem_ack
- mem_busy  in  1  memory busy
- mem_ack  in  1  memory completion pulse
- inv  in  1  invalidate all lines (used after oob loads)
- hit_count  out  32  read hits since reset, wraps
- miss_count  out  32  read misses since reset, wraps

Behaviour:
- Address split: index = cpu_addr[2+IDX_BITS-1:2]; tag = cpu_addr[31:2+IDX_BITS].
- Per line: valid bit, tag, 32-bit data.
- Reset, and immediately after reset: all outputs 0, all valid bits 0, counters 0, state IDLE.
- Accept rule: a request is accepted only in IDLE when cpu_busy=0. Requests in other states are dropped.
- cpu_wr_req and cpu_rd_req together: treated as a write.
- cpu_busy: high from the cycle after accept through the cpu_ack cycle inclusive; low the following cycle.
- Read hit (valid and tag match, evaluated at accept):
  - IDLE -> HIT_ACK.
  - Next cycle: cpu_ack=1, cpu_rd_data=line data, hit_count+1.
  - Back-to-back request earliest 2 cycles after the previous one.
- Read miss:
  - IDLE -> MISS_REQ; miss_count+1.
  - MISS_REQ: wait for mem_busy=0, then drive mem_rd_req=1 for exactly 1 cycle with mem_addr={cpu_addr[31:2],2'b00}, latched at accept.
  - -> MISS_WAIT. On mem_ack: write line (valid=1, tag, data=mem_rd_data) -> ACK.
  - ACK: cpu_ack=1, cpu_rd_data=filled data -> IDLE.
- Write:
  - IDLE -> WR_REQ. If the line hits, update line data at accept. On a miss, leave the line untouched.
  - WR_REQ: wait for mem_busy=0, then pulse mem_wr_req for 1 cycle with latched addr/data -> WR_WAIT.
  - WR_WAIT: on mem_ack -> ACK.
  - ACK: cpu_ack=1, cpu_rd_data=0 -> IDLE.
- mem_rd_req, mem_wr_req, cpu_ack are never high for 2 consecutive cycles.
- mem_ack outside MISS_WAIT/WR_WAIT is ignored.
- inv: clears every valid bit at the end of the cycle, in any state.
  - inv in the same cycle as a miss fill: the fill's data still returns to the cpu, but the line is left invalid (inv wins).
  - inv does not abort an in-flight request.
- Reset mid-operation: everything returns to the reset state. A mem_ack arriving later lands in IDLE and is ignored.
- Latched registers: address, write data and tag are captured at accept. cpu_* inputs are don't-care afterwards.

Decomposition:
- dcache_pkg holds:
  - state enum {IDLE, HIT_ACK, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, ACK};
  - WORD_W=32;
  - helper functions addr_index/addr_tag, parameterised by IDX_BITS.
- Sub-module dcache_array holds valid/tag/data storage:
  - combinational lookup, reporting hit and data;
  - single write port;
  - synchronous clear-all, used by rst and inv.
- The FSM and counters stay in dcache_direct.

Test Plan:
- Cold read 0x40, memory holding 0xDEADBEEF with 3-cycle delay -> one mem_rd_req at addr 0x40; cpu_ack with 0xDEADBEEF; miss_count=1.
- Re-read 0x40 -> no mem_rd_req; cpu_ack exactly 1 cycle after accept with 0xDEADBEEF; hit_count=1.
- Write 0x12345678 to 0x40, then read 0x40 -> mem_wr_req addr 0x40 data 0x12345678; subsequent read hits and returns 0x12345678.
- Conflict, NUM_LINES=16: read 0x40 then 0x80 (same index), then 0x40 -> 3 misses, 3 mem_rd_req, correct data each time.
- Pulse inv after filling 0x40, re-read -> miss, mem_rd_req issued. Separately, inv in the MISS_WAIT mem_ack cycle -> data returned, next read of same address misses.
- Assert rst during MISS_WAIT, then deliver mem_ack -> all outputs 0, no cpu_ack, counters 0, next request served normally.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address helpers for the direct-mapped data cache
package dcache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      HIT_ACK,
      MISS_REQ,
      MISS_WAIT,
      WR_REQ,
      WR_WAIT,
      ACK
   } state_e;

   // Line index of a byte address; result is right-aligned, caller keeps the low idx_bits.
   function automatic logic [WORD_W-1:0] addr_index(input logic [WORD_W-1:0] addr, input int idx_bits);
      return (addr >> 2) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

   // Tag of a byte address; right-aligned, caller keeps the low WORD_W-2-idx_bits bits.
   function automatic logic [WORD_W-1:0] addr_tag(input logic [WORD_W-1:0] addr, input int idx_bits);
      return addr >> (2 + idx_bits);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data line storage with combinational lookup and one write port
module dcache_array
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_BITS  = 4,
   parameter int TAG_W     = 26
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [IDX_BITS-1:0] lk_idx,
   input  logic [TAG_W-1:0]    lk_tag,
   output logic                lk_hit,
   output logic [WORD_W-1:0]   lk_data,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic [WORD_W-1:0]   wr_data
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   logic [WORD_W-1:0]    data_q [NUM_LINES];
   logic [WORD_W-1:0]    data_d [NUM_LINES];

   assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_data = data_q[lk_idx];

   // Next line contents: apply the write port, then a clear-all wins over any same-cycle write.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_data;
      end
      if (clr) begin
         valid_d = '0;
      end
   end

   // Storage registers; tag/data need no reset because valid gates every lookup.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
   end

endmodule

// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through no-write-allocate data cache
module dcache_direct
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_rd_req,
   input  logic        cpu_wr_req,
   input  logic [31:0] cpu_wr_data,
   output logic [31:0] cpu_rd_data,
   output logic        cpu_busy,
   output logic        cpu_ack,
   output logic [31:0] mem_addr,
   output logic        mem_rd_req,
   output logic        mem_wr_req,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_busy,
   input  logic        mem_ack,
   input  logic        inv,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_W    = WORD_W - 2 - IDX_BITS;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;
   logic                mem_rd_q, mem_rd_d;
   logic                mem_wr_q, mem_wr_d;
   logic [WORD_W-1:0]   hit_q, hit_d;
   logic [WORD_W-1:0]   miss_q, miss_d;

   logic [WORD_W-1:0]   lk_idx_w, lk_tag_w, fl_idx_w, fl_tag_w;
   logic                lk_hit;
   logic [WORD_W-1:0]   lk_data;
   logic                arr_we;
   logic [IDX_BITS-1:0] arr_idx;
   logic [TAG_W-1:0]    arr_tag;
   logic [WORD_W-1:0]   arr_data;
   logic                unused_addr_bits;

   // Lookups use the live cpu address; fills use the address latched at accept.
   assign lk_idx_w = addr_index(cpu_addr, IDX_BITS);
   assign lk_tag_w = addr_tag(cpu_addr, IDX_BITS);
   assign fl_idx_w = addr_index(addr_q, IDX_BITS);
   assign fl_tag_w = addr_tag(addr_q, IDX_BITS);
   assign unused_addr_bits = ^{lk_idx_w[WORD_W-1:IDX_BITS], lk_tag_w[WORD_W-1:TAG_W],
                               fl_idx_w[WORD_W-1:IDX_BITS], fl_tag_w[WORD_W-1:TAG_W]};

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_BITS  (IDX_BITS),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk     (clk),
      .clr     (rst | inv),
      .lk_idx  (lk_idx_w[IDX_BITS-1:0]),
      .lk_tag  (lk_tag_w[TAG_W-1:0]),
      .lk_hit  (lk_hit),
      .lk_data (lk_data),
      .wr_en   (arr_we),
      .wr_idx  (arr_idx),
      .wr_tag  (arr_tag),
      .wr_data (arr_data)
   );

   // Control: accept in IDLE, route reads/writes, build pulses and array write port.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = '0;
      ack_d    = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      hit_d    = hit_q;
      miss_d   = miss_q;
      arr_we   = 1'b0;
      arr_idx  = lk_idx_w[IDX_BITS-1:0];
      arr_tag  = lk_tag_w[TAG_W-1:0];
      arr_data = cpu_wr_data;
      case (state_q)
         IDLE: begin
            if (cpu_wr_req) begin
               addr_d  = {cpu_addr[31:2], 2'b00};
               wdata_d = cpu_wr_data;
               arr_we  = lk_hit;
               state_d = WR_REQ;
            end else if (cpu_rd_req) begin
               addr_d = {cpu_addr[31:2], 2'b00};
               if (lk_hit) begin
                  rdata_d = lk_data;
                  ack_d   = 1'b1;
                  hit_d   = hit_q + 32'd1;
                  state_d = HIT_ACK;
               end else begin
                  miss_d  = miss_q + 32'd1;
                  state_d = MISS_REQ;
               end
            end
         end
         HIT_ACK: state_d = IDLE;
         MISS_REQ: begin
            if (!mem_busy) begin
               mem_rd_d = 1'b1;
               state_d  = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (mem_ack) begin
               arr_we   = 1'b1;
               arr_idx  = fl_idx_w[IDX_BITS-1:0];
               arr_tag  = fl_tag_w[TAG_W-1:0];
               arr_data = mem_rd_data;
               rdata_d  = mem_rd_data;
               ack_d    = 1'b1;
               state_d  = ACK;
            end
         end
         WR_REQ: begin
            if (!mem_busy) begin
               mem_wr_d = 1'b1;
               state_d  = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (mem_ack) begin
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // FSM state, latched request and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   assign cpu_rd_data = rdata_q;
   assign cpu_busy    = busy_q;
   assign cpu_ack     = ack_q;
   assign mem_addr    = addr_q;
   assign mem_rd_req  = mem_rd_q;
   assign mem_wr_req  = mem_wr_q;
   assign mem_wr_data = wdata_q;
   assign hit_count   = hit_q;
   assign miss_count  = miss_q;

endmodule
